// File: rtl/rom_download_ctrl.sv
// MiSTer ioctl ROM download sequencer: splits the byte stream into 4 ROM regions and holds the core in reset until loaded.
// Optional feature macro: ROM_DL_CHECKSUM_EN (running 16-bit byte sum of accepted bytes).
module rom_download_ctrl #(
  parameter int unsigned AW          = 16,
  parameter int unsigned RELEASE_CYC = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW+2:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic [AW-1:0] load_addr,
  output logic [7:0]    load_data,
  output logic [3:0]    load_we,
  output logic          sys_hold,
  output logic          dl_done,
  output logic          dl_err,
  output logic [15:0]   checksum
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned RGN_W = 3;
  localparam int unsigned WE_W  = 4;
  localparam int unsigned SUM_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               hold_n, done_n, err_n;
  logic [WE_W-1:0]    we_n;
  logic [AW-1:0]      addr_n;
  logic [7:0]         data_n;
  logic [RGN_W-1:0]   region;
  logic               accept;
  logic               in_range;
  logic               enter_load;

  assign region   = dl_addr[AW+2:AW];
  assign accept   = (state == LOAD) && dl_wr;
  assign in_range = !region[RGN_W-1];

  // Sequencing: a re-rise of dl_active during SETTLE wins over the final count.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold_n  = sys_hold;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (dl_active) begin
          state_n = LOAD;
          hold_n  = 1'b1;
        end
      end
      LOAD: begin
        hold_n = 1'b1;
        if (!dl_active) begin
          state_n = SETTLE;
          cnt_n   = CNT_W'(RELEASE_CYC);
        end
      end
      SETTLE: begin
        hold_n = 1'b1;
        if (dl_active) begin
          state_n = LOAD;
        end else if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          hold_n  = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        hold_n  = 1'b1;
      end
    endcase
  end

  assign enter_load = (state != LOAD) && (state_n == LOAD);

  // Byte path: out-of-range bytes only flag the error, ROM address/data stay put.
  always_comb begin
    we_n   = '0;
    addr_n = load_addr;
    data_n = load_data;
    err_n  = dl_err;
    if (enter_load) begin
      err_n = 1'b0;
    end
    if (accept) begin
      if (in_range) begin
        we_n   = WE_W'(1) << region[1:0];
        addr_n = dl_addr[AW-1:0];
        data_n = dl_data;
      end else begin
        err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sys_hold  <= 1'b1;
      dl_done   <= 1'b0;
      dl_err    <= 1'b0;
      load_we   <= '0;
      load_addr <= '0;
      load_data <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sys_hold  <= hold_n;
      dl_done   <= done_n;
      dl_err    <= err_n;
      load_we   <= we_n;
      load_addr <= addr_n;
      load_data <= data_n;
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  logic [SUM_W-1:0] sum_q, sum_n;

  always_comb begin
    sum_n = sum_q;
    if (enter_load) begin
      sum_n = '0;
    end
    if (accept && in_range) begin
      sum_n = sum_q + SUM_W'(dl_data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_n;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = SUM_W'(0);
`endif

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Self-checking bench for rom_download_ctrl: directed scenarios plus randomized downloads against a behavioural model.
module tb_rom_download_ctrl;

  localparam int unsigned AW          = 16;
  localparam int unsigned RELEASE_CYC = 16;
`ifdef ROM_DL_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dl_active = 1'b0;
  logic          dl_wr = 1'b0;
  logic [AW+2:0] dl_addr = '0;
  logic [7:0]    dl_data = '0;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic [3:0]    load_we;
  logic          sys_hold;
  logic          dl_done;
  logic          dl_err;
  logic [15:0]   checksum;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [AW-1:0] exp_addr = '0;
  logic [7:0]    exp_data = '0;
  logic [3:0]    exp_we   = '0;
  logic          exp_err  = 1'b0;
  logic [15:0]   exp_sum  = '0;

  rom_download_ctrl #(.AW(AW), .RELEASE_CYC(RELEASE_CYC)) dut (
    .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .load_addr(load_addr),
    .load_data(load_data), .load_we(load_we), .sys_hold(sys_hold),
    .dl_done(dl_done), .dl_err(dl_err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [2:0] r, input logic [15:0] off, input logic [7:0] d);
    dl_wr   = 1'b1;
    dl_addr = {r, off};
    dl_data = d;
  endtask

  function automatic void model_write(input logic [2:0] r, input logic [15:0] off, input logic [7:0] d);
    if (r < 3'd4) begin
      exp_we   = 4'b0001 << r[1:0];
      exp_addr = off;
      exp_data = d;
      exp_sum  = exp_sum + 16'(d);
    end else begin
      exp_we  = 4'b0000;
      exp_err = 1'b1;
    end
  endfunction

  function automatic logic [15:0] cs(input logic [15:0] s);
    return CS_EN ? s : 16'h0000;
  endfunction

  task automatic finish_download;
    dl_active = 1'b0;
    repeat (RELEASE_CYC + 1) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (sys_hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b expected 1", sys_hold); end
    checks++; if (load_we !== 4'b0) begin errors++; $display("FAIL reset_we: got %b expected 0000", load_we); end
    checks++; if ({load_addr, load_data} !== 24'h0) begin errors++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", load_addr, load_data); end
    checks++; if ({dl_done, dl_err} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b%b expected 00", dl_done, dl_err); end
    checks++; if (checksum !== 16'h0) begin errors++; $display("FAIL reset_checksum: got %h expected 0000", checksum); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (sys_hold !== 1'b1 || dl_done !== 1'b0 || load_we !== 4'b0) begin
        errors++; $display("FAIL idle_after_reset: cycle %0d hold=%b done=%b we=%b expected 1/0/0000", i, sys_hold, dl_done, load_we);
      end
    end
  endtask

  task automatic test_basic;
    dl_active = 1'b1;
    tick();
    exp_sum = '0; exp_err = 1'b0;
    set_wr(3'd0, 16'h0000, 8'hA5); model_write(3'd0, 16'h0000, 8'hA5);
    tick(); dl_wr = 1'b0;
    checks++; if ({load_we, load_addr, load_data} !== {4'b0001, 16'h0000, 8'hA5}) begin
      errors++; $display("FAIL basic_byte0: got we=%b addr=%h data=%h expected 0001/0000/a5", load_we, load_addr, load_data); end
    set_wr(3'd1, 16'hFFFF, 8'h3C); model_write(3'd1, 16'hFFFF, 8'h3C);
    tick(); dl_wr = 1'b0;
    checks++; if ({load_we, load_addr, load_data} !== {4'b0010, 16'hFFFF, 8'h3C}) begin
      errors++; $display("FAIL basic_byte1: got we=%b addr=%h data=%h expected 0010/ffff/3c", load_we, load_addr, load_data); end
    tick();
    checks++; if ({load_we, load_addr, load_data} !== {4'b0000, 16'hFFFF, 8'h3C}) begin
      errors++; $display("FAIL basic_hold: got we=%b addr=%h data=%h expected 0000/ffff/3c", load_we, load_addr, load_data); end
    checks++; if (checksum !== cs(16'h00E1)) begin errors++; $display("FAIL basic_checksum: got %h expected %h", checksum, cs(16'h00E1)); end
  endtask

  task automatic test_settle;
    dl_active = 1'b0;
    for (int i = 0; i < int'(RELEASE_CYC); i++) begin
      tick();
      checks++; if (sys_hold !== 1'b1 || dl_done !== 1'b0) begin
        errors++; $display("FAIL settle_hold: cycle %0d hold=%b done=%b expected 1/0", i, sys_hold, dl_done); end
    end
    tick();
    checks++; if (sys_hold !== 1'b0 || dl_done !== 1'b1) begin
      errors++; $display("FAIL settle_release: hold=%b done=%b expected 0/1", sys_hold, dl_done); end
    tick();
    checks++; if (sys_hold !== 1'b0 || dl_done !== 1'b0) begin
      errors++; $display("FAIL settle_pulse_width: hold=%b done=%b expected 0/0", sys_hold, dl_done); end
    dl_active = 1'b1;
    tick();
    checks++; if (sys_hold !== 1'b1) begin errors++; $display("FAIL restart_hold: got %b expected 1", sys_hold); end
    // Drop, then re-rise while the settle count reads 5
    dl_active = 1'b0;
    repeat (12) tick();
    dl_active = 1'b1;
    for (int i = 0; i < int'(RELEASE_CYC) + 3; i++) begin
      tick();
      checks++; if (sys_hold !== 1'b1 || dl_done !== 1'b0) begin
        errors++; $display("FAIL rerise_no_done: cycle %0d hold=%b done=%b expected 1/0", i, sys_hold, dl_done); end
    end
    dl_active = 1'b0;
    repeat (RELEASE_CYC) tick();
    tick();
    checks++; if (sys_hold !== 1'b0 || dl_done !== 1'b1) begin
      errors++; $display("FAIL rerise_full_settle: hold=%b done=%b expected 0/1", sys_hold, dl_done); end
  endtask

  task automatic test_err;
    dl_active = 1'b1;
    tick();
    exp_sum = '0; exp_err = 1'b0;
    set_wr(3'd4, 16'h0000, 8'h77); model_write(3'd4, 16'h0000, 8'h77);
    tick(); dl_wr = 1'b0;
    checks++; if (load_we !== 4'b0000 || dl_err !== 1'b1) begin
      errors++; $display("FAIL err_flag: we=%b err=%b expected 0000/1", load_we, dl_err); end
    checks++; if (load_addr !== exp_addr || load_data !== exp_data) begin
      errors++; $display("FAIL err_no_update: addr=%h data=%h expected %h/%h", load_addr, load_data, exp_addr, exp_data); end
    checks++; if (checksum !== cs(16'h0)) begin errors++; $display("FAIL err_not_summed: got %h expected 0000", checksum); end
    finish_download();
    checks++; if (dl_err !== 1'b1 || sys_hold !== 1'b0) begin
      errors++; $display("FAIL err_sticky: err=%b hold=%b expected 1/0", dl_err, sys_hold); end
    dl_active = 1'b1;
    tick();
    exp_err = 1'b0; exp_sum = '0;
    checks++; if (dl_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", dl_err); end
  endtask

  task automatic test_mid_reset;
    set_wr(3'd2, 16'h1234, 8'h5A);
    reset = 1'b1;
    tick();
    checks++; if (load_we !== 4'b0000 || sys_hold !== 1'b1) begin
      errors++; $display("FAIL midreset_we_hold: we=%b hold=%b expected 0000/1", load_we, sys_hold); end
    reset = 1'b0; dl_wr = 1'b0; dl_active = 1'b0;
    exp_addr = '0; exp_data = '0; exp_err = 1'b0; exp_sum = '0;
    for (int i = 0; i < int'(RELEASE_CYC) + 4; i++) begin
      tick();
      checks++; if (sys_hold !== 1'b1 || dl_done !== 1'b0) begin
        errors++; $display("FAIL midreset_idle: cycle %0d hold=%b done=%b expected 1/0", i, sys_hold, dl_done); end
    end
    checks++; if (load_addr !== 16'h0 || dl_err !== 1'b0) begin
      errors++; $display("FAIL midreset_state: addr=%h err=%b expected 0000/0", load_addr, dl_err); end
  endtask

  task automatic test_checksum;
    logic [2:0]  rs [4] = '{3'd0, 3'd1, 3'd3, 3'd5};
    logic [7:0]  ds [4] = '{8'hFF, 8'hFF, 8'h02, 8'h80};
    dl_active = 1'b1;
    tick();
    exp_sum = '0; exp_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_wr(rs[i], 16'(i * 3), ds[i]); model_write(rs[i], 16'(i * 3), ds[i]);
      tick(); dl_wr = 1'b0;
    end
    checks++; if (checksum !== cs(16'h0200)) begin errors++; $display("FAIL checksum_ff_ff_02: got %h expected %h", checksum, cs(16'h0200)); end
    finish_download();
    checks++; if (checksum !== cs(16'h0200)) begin errors++; $display("FAIL checksum_after_settle: got %h expected %h", checksum, cs(16'h0200)); end
  endtask

  task automatic test_random;
    logic [2:0]  r;
    logic [15:0] off;
    logic [7:0]  d;
    int n;
    for (int t = 0; t < 6; t++) begin
      // Writes while idle must be ignored
      set_wr(3'($urandom_range(0, 3)), 16'($urandom), 8'($urandom));
      tick(); dl_wr = 1'b0;
      checks++; if (load_we !== 4'b0 || checksum !== cs(exp_sum) || load_addr !== exp_addr) begin
        errors++; $display("FAIL rnd_idle_ignore: we=%b cs=%h addr=%h expected 0000/%h/%h", load_we, checksum, load_addr, cs(exp_sum), exp_addr); end
      dl_active = 1'b1;
      tick();
      exp_sum = '0; exp_err = 1'b0;
      checks++; if (sys_hold !== 1'b1 || dl_err !== 1'b0 || checksum !== 16'h0) begin
        errors++; $display("FAIL rnd_start: hold=%b err=%b cs=%h expected 1/0/0000", sys_hold, dl_err, checksum); end
      n = int'($urandom_range(3, 10));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          checks++; if (load_we !== 4'b0 || load_addr !== exp_addr || load_data !== exp_data) begin
            errors++; $display("FAIL rnd_gap: we=%b addr=%h data=%h expected 0000/%h/%h", load_we, load_addr, load_data, exp_addr, exp_data); end
        end
        r   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        off = 16'($urandom);
        d   = 8'($urandom);
        if (i == n - 1) dl_active = 1'b0;
        set_wr(r, off, d); model_write(r, off, d);
        tick(); dl_wr = 1'b0;
        checks++; if ({load_we, load_addr, load_data, dl_err} !== {exp_we, exp_addr, exp_data, exp_err} || checksum !== cs(exp_sum)) begin
          errors++; $display("FAIL rnd_byte: we=%b addr=%h data=%h err=%b cs=%h expected %b/%h/%h/%b/%h",
                             load_we, load_addr, load_data, dl_err, checksum, exp_we, exp_addr, exp_data, exp_err, cs(exp_sum)); end
      end
      for (int k = 1; k < int'(RELEASE_CYC); k++) begin
        tick();
        checks++; if (sys_hold !== 1'b1 || dl_done !== 1'b0) begin
          errors++; $display("FAIL rnd_settle: cycle %0d hold=%b done=%b expected 1/0", k, sys_hold, dl_done); end
      end
      tick();
      checks++; if (sys_hold !== 1'b0 || dl_done !== 1'b1 || dl_err !== exp_err) begin
        errors++; $display("FAIL rnd_release: hold=%b done=%b err=%b expected 0/1/%b", sys_hold, dl_done, dl_err, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_settle();
    test_err();
    test_mid_reset();
    test_checksum();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
